// File: rtl/deint_seq_ctrl.sv
// Serial decimating sequencer: collects one interpolated symbol, keeps every
// INT_FACTOR-th sample from a programmable phase, then drains the kept samples
// as a valid/ready stream with a last-beat marker.
module deint_seq_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int TOTAL_SAMPLES = 16,
  parameter int INT_SAMPLES   = 128,
  parameter int INT_FACTOR    = INT_SAMPLES / TOTAL_SAMPLES,
  parameter int PW            = (INT_FACTOR > 1) ? $clog2(INT_FACTOR) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [PW-1:0]                i_phase,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_re,
  input  logic signed [DATA_WIDTH-1:0] i_im,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic signed [DATA_WIDTH-1:0] o_re,
  output logic signed [DATA_WIDTH-1:0] o_im,
  output logic                         o_last,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int CW = (INT_SAMPLES > 1) ? $clog2(INT_SAMPLES) : 1;
  localparam int IW = (TOTAL_SAMPLES > 1) ? $clog2(TOTAL_SAMPLES) : 1;
  localparam logic [CW-1:0] LastIn  = CW'(INT_SAMPLES - 1);
  localparam logic [IW-1:0] LastOut = IW'(TOTAL_SAMPLES - 1);
  localparam logic [PW-1:0] LastSub = PW'(INT_FACTOR - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e                         r_state, w_state_d;
  logic [CW-1:0]                  r_in_cnt;
  logic [PW-1:0]                  r_sub;    // in_cnt mod INT_FACTOR, tracked incrementally
  logic [PW-1:0]                  r_phase;
  logic [IW-1:0]                  r_wr_idx, r_rd_idx;
  logic signed [DATA_WIDTH-1:0]   r_buf_re [TOTAL_SAMPLES];
  logic signed [DATA_WIDTH-1:0]   r_buf_im [TOTAL_SAMPLES];
  logic                           r_done, r_err;

  logic w_beat, w_xfer, w_keep, w_out_last;

  assign w_beat     = (r_state == StCollect) && i_valid;
  assign w_xfer     = (r_state == StDrain) && i_ready;
  assign w_keep     = (r_sub == r_phase);
  assign w_out_last = (r_rd_idx == LastOut);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_d = r_state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_d = StCollect;
      end
      StCollect: begin
        o_ready = 1'b1;
        if (i_valid && (r_in_cnt == LastIn)) w_state_d = StDrain;
      end
      StDrain: begin
        o_valid = 1'b1;
        if (i_ready && w_out_last) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Counters, phase latch, sample buffer and one-cycle status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_cnt <= '0;
      r_sub    <= '0;
      r_phase  <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      for (int k = 0; k < TOTAL_SAMPLES; k++) begin
        r_buf_re[k] <= '0;
        r_buf_im[k] <= '0;
      end
    end else begin
      r_done <= w_xfer && w_out_last;
      r_err  <= i_start && (r_state != StIdle);
      if ((r_state == StIdle) && i_start) begin
        r_phase  <= (INT_FACTOR == 1) ? '0 : i_phase;
        r_in_cnt <= '0;
        r_sub    <= '0;
        r_wr_idx <= '0;
        r_rd_idx <= '0;
      end
      if (w_beat) begin
        r_in_cnt <= r_in_cnt + 1'b1;
        r_sub    <= (r_sub == LastSub) ? '0 : r_sub + 1'b1;
        if (w_keep) begin
          r_buf_re[r_wr_idx] <= i_re;
          r_buf_im[r_wr_idx] <= i_im;
          r_wr_idx <= (r_wr_idx == LastOut) ? '0 : r_wr_idx + 1'b1;
        end
      end
      if (w_xfer) r_rd_idx <= w_out_last ? '0 : r_rd_idx + 1'b1;
    end
  end

  // Data is forced to zero outside DRAIN so idle cycles carry no stale samples.
  assign o_re   = (r_state == StDrain) ? r_buf_re[r_rd_idx] : '0;
  assign o_im   = (r_state == StDrain) ? r_buf_im[r_rd_idx] : '0;
  assign o_last = (r_state == StDrain) && w_out_last;
  assign o_busy = (r_state != StIdle);
  assign o_done = r_done;
  assign o_err  = r_err;

endmodule

// File: tb/tb_deint_seq_ctrl.sv
// Self-checking bench for deint_seq_ctrl: randomized frames against a
// sample-index reference model, plus hand-computed pins on captured outputs.
module tb_deint_seq_ctrl;

  localparam int DW = 16;
  localparam int T  = 16;
  localparam int IS = 128;
  localparam int F  = IS / T;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_start, i_valid, i_ready;
  logic [2:0]           i_phase;
  logic signed [DW-1:0] i_re, i_im;
  logic                 o_ready, o_valid, o_last, o_busy, o_done, o_err;
  logic signed [DW-1:0] o_re, o_im;

  int n_chk = 0;
  int n_err = 0;

  deint_seq_ctrl #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(T), .INT_SAMPLES(IS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (i_start),
    .i_phase (i_phase),
    .i_valid (i_valid),
    .i_re    (i_re),
    .i_im    (i_im),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_re    (o_re),
    .o_im    (o_im),
    .o_last  (o_last),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a frame is the list of accepted samples; output k is
  // sample k*F+phase once all IS samples have arrived.
  logic signed [DW-1:0] m_re [IS];
  logic signed [DW-1:0] m_im [IS];
  bit m_act, m_done_p, m_err_p;
  int m_ph, m_in, m_out;
  bit pv, pr, pl;
  logic signed [DW-1:0] pre, pim;

  // Captured transfers and pulse counts for the literal pins.
  int cap_re[$];
  int cap_im[$];
  int cap_last[$];
  int done_cnt, err_cnt;

  // Compare process: check every output on the falling edge, then advance model.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_done_p = 0; m_err_p = 0; m_in = 0; m_out = 0; pv = 0;
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy",  o_busy,  0);
      chk("rst_done",  o_done,  0);
      chk("rst_err",   o_err,   0);
      chk("rst_last",  o_last,  0);
      chk("rst_re",    o_re,    0);
      chk("rst_im",    o_im,    0);
    end else begin
      bit e_ready, e_valid;
      e_ready = m_act && (m_in < IS);
      e_valid = m_act && (m_in == IS);
      chk("ready", o_ready, e_ready);
      chk("valid", o_valid, e_valid);
      chk("busy",  o_busy,  m_act);
      chk("done",  o_done,  m_done_p);
      chk("err",   o_err,   m_err_p);
      if (e_valid) begin
        chk("data_re", o_re,   m_re[m_out*F + m_ph]);
        chk("data_im", o_im,   m_im[m_out*F + m_ph]);
        chk("last",    o_last, (m_out == T-1));
      end else begin
        chk("idle_re",   o_re,   0);
        chk("idle_im",   o_im,   0);
        chk("idle_last", o_last, 0);
      end
      if (pv && !pr && o_valid) begin
        chk("hold_re",   o_re,   pre);
        chk("hold_im",   o_im,   pim);
        chk("hold_last", o_last, pl);
      end
      pv = o_valid; pr = i_ready; pre = o_re; pim = o_im; pl = o_last;
      if (o_valid && i_ready) begin
        cap_re.push_back(int'(o_re));
        cap_im.push_back(int'(o_im));
        cap_last.push_back(int'(o_last));
      end
      if (o_done) done_cnt++;
      if (o_err)  err_cnt++;
      m_done_p = 0;
      m_err_p  = 0;
      if (m_act) begin
        if (i_start) m_err_p = 1;
        if (e_ready && i_valid) begin
          m_re[m_in] = i_re;
          m_im[m_in] = i_im;
          m_in++;
        end else if (e_valid && i_ready) begin
          m_out++;
          if (m_out == T) begin
            m_act = 0;
            m_done_p = 1;
          end
        end
      end else if (i_start) begin
        m_act = 1; m_ph = int'(i_phase); m_in = 0; m_out = 0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps;
    cap_re.delete(); cap_im.delete(); cap_last.delete();
    done_cnt = 0; err_cnt = 0;
  endtask

  // One frame: start, feed IS samples (with gaps), drain T outputs (with stalls).
  // err_beat >= 0 sends a stray start at that input beat; rst_xfer >= 0 resets
  // after that many output transfers.
  task automatic run_frame(input int ph, input bit ramp, input int gap_pct,
                           input int rdy_pct, input int err_beat, input int rst_xfer);
    int n, x, cyc;
    bit sent, acc;
    i_start = 1'b1; i_phase = 3'(ph); i_valid = 1'b0; i_ready = 1'b1;
    step();
    i_start = 1'b0;
    n = 0; cyc = 0; sent = 0;
    while (n < IS && cyc < 3000) begin
      i_valid = ($urandom_range(99) >= gap_pct);
      i_re    = ramp ? 16'(n)  : 16'($urandom);
      i_im    = ramp ? 16'(-n) : 16'($urandom);
      i_ready = $urandom_range(1) == 1;
      i_start = 1'b0;
      if (n == err_beat && !sent) begin
        i_start = 1'b1; i_phase = 3'd7; sent = 1;
      end
      acc = i_valid && o_ready;
      step();
      if (acc) n++;
      cyc++;
    end
    chk("collect_beats", n, IS);
    i_valid = 1'b0; i_start = 1'b0;
    x = 0; cyc = 0;
    while (x < T && cyc < 3000) begin
      i_ready = ($urandom_range(99) < rdy_pct);
      if (x == rst_xfer) begin
        rst_n = 1'b0;
        #1;
        chk("rst_now_valid", o_valid, 0);
        chk("rst_now_busy",  o_busy,  0);
        step(); step();
        rst_n = 1'b0;
        i_ready = 1'b0;
        rst_n = 1'b1;
        return;
      end
      acc = i_ready && o_valid;
      step();
      if (acc) x++;
      cyc++;
    end
    chk("drain_xfers", x, T);
    i_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_start = 0; i_phase = 0; i_valid = 0; i_ready = 0; i_re = 0; i_im = 0;
    clear_caps();
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_ready", o_ready, 0);
    chk("idle_busy",  o_busy,  0);

    // Ramp, phase 0
    clear_caps();
    run_frame(0, 1, 0, 100, -1, -1);
    step();
    chk("p0_count", cap_re.size(), 16);
    chk("p0_re0",   cap_re[0], 0);
    chk("p0_re1",   cap_re[1], 8);
    chk("p0_re15",  cap_re[15], 120);
    chk("p0_im15",  cap_im[15], -120);
    chk("p0_last15", cap_last[15], 1);
    chk("p0_last14", cap_last[14], 0);
    chk("p0_done",  done_cnt, 1);

    // Ramp, phase 5
    clear_caps();
    run_frame(5, 1, 0, 100, -1, -1);
    step();
    chk("p5_re0",  cap_re[0], 5);
    chk("p5_re1",  cap_re[1], 13);
    chk("p5_re15", cap_re[15], 125);
    chk("p5_err",  err_cnt, 0);

    // Backpressure on both sides, same ramp
    clear_caps();
    run_frame(0, 1, 40, 50, -1, -1);
    step();
    chk("bp_count", cap_re.size(), 16);
    chk("bp_re7",   cap_re[7], 56);
    chk("bp_re15",  cap_re[15], 120);

    // Stray start while busy
    clear_caps();
    run_frame(0, 1, 0, 100, 40, -1);
    step();
    chk("busy_err", err_cnt, 1);
    chk("busy_re3", cap_re[3], 24);
    chk("busy_re15", cap_re[15], 120);

    // Reset in DRAIN after 7 transfers, then a phase-3 frame
    clear_caps();
    run_frame(0, 1, 0, 100, -1, 7);
    step();
    chk("rst_partial_done", done_cnt, 0);
    clear_caps();
    run_frame(3, 1, 10, 70, -1, -1);
    step();
    chk("p3_count", cap_re.size(), 16);
    chk("p3_re0",   cap_re[0], 3);
    chk("p3_re15",  cap_re[15], 123);
    chk("p3_done",  done_cnt, 1);

    // Back-to-back frames: second start in the done cycle
    clear_caps();
    run_frame(2, 0, 0, 100, -1, -1);
    chk("b2b_done_now", o_done, 1);
    run_frame(6, 1, 0, 100, -1, -1);
    step();
    chk("b2b_count", cap_re.size(), 32);
    chk("b2b_re16",  cap_re[16], 6);
    chk("b2b_done",  done_cnt, 2);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      run_frame(int'($urandom_range(7)), 0, 25, 60, -1, -1);
      repeat ($urandom_range(3)) step();
    end
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/deint_seq_ctrl.md
# deint_seq_ctrl

Streaming sequencer for the receive-side resampling stage. It accepts one interpolated symbol of INT_SAMPLES complex samples as a serial valid/ready stream and keeps every INT_FACTOR-th sample, starting at a programmable phase offset. The TOTAL_SAMPLES kept samples go into an internal register buffer and are then drained as a serial valid/ready stream with a last-beat marker. It sits between the interpolated-sample source and the downstream SC-FDMA demodulation chain. It replaces the fully parallel resampler wherever samples arrive serially.

## Interface
- DATA_WIDTH, 16: signed width of each I/Q component.
- TOTAL_SAMPLES, 16: samples kept per symbol (buffer depth).
- INT_SAMPLES, 128: samples received per symbol.
- INT_FACTOR, derived = INT_SAMPLES/TOTAL_SAMPLES: decimation factor. Must be an integer ≥1.
- PW, derived = max(1, $clog2(INT_FACTOR)): phase width.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse that opens a symbol frame.
- i_phase  in  PW  decimation phase, latched on an accepted i_start.
- i_valid  in  1  input sample valid.
- i_re, i_im  in  DATA_WIDTH each  input sample (signed).
- o_ready  out  1  input ready.
- o_valid  out  1  output sample valid.
- o_re, o_im  out  DATA_WIDTH each  output sample (signed).
- o_last  out  1  marks the final (TOTAL_SAMPLES-th) output beat.
- i_ready  in  1  downstream ready.
- o_busy  out  1  high whenever the state is not IDLE.
- o_done  out  1  one-cycle pulse after the last output transfer.
- o_err  out  1  one-cycle pulse when i_start is received while busy.

## Operation
- FSM states: IDLE, COLLECT, DRAIN. Counters: in_cnt (0..INT_SAMPLES-1), wr_idx and rd_idx (0..TOTAL_SAMPLES-1).
- IDLE:
  - o_ready=0, o_valid=0.
  - On i_start: latch i_phase (forced to 0 when INT_FACTOR=1), clear all counters, go to COLLECT.
- COLLECT:
  - o_ready=1. A beat is i_valid && o_ready.
  - On each beat with (in_cnt mod INT_FACTOR) == phase: write buffer[wr_idx] and increment wr_idx.
  - in_cnt increments on every beat.
  - The beat with in_cnt == INT_SAMPLES-1 moves the FSM to DRAIN. Input data on the cycle of that transition is not accepted.
- DRAIN:
  - o_ready=0, o_valid=1.
  - o_re/o_im = buffer[rd_idx].
  - A transfer is o_valid && i_ready; each transfer increments rd_idx.
  - o_last = (rd_idx == TOTAL_SAMPLES-1).
  - The transfer with o_last high moves the FSM to IDLE.
- Output mapping: output k = input sample k*INT_FACTOR + phase. Data passes through bit-exact, with no arithmetic or rounding.
- o_re/o_im are driven to 0 whenever o_valid=0.
- i_start while in COLLECT or DRAIN: ignored. o_err pulses for 1 cycle; the frame in progress is unaffected.
- i_valid while in IDLE is ignored, because o_ready=0.

## Timing
- Reset (i_rst_n low, takes effect immediately):
  - State goes to IDLE and all counters clear.
  - Buffer is cleared to 0.
  - o_ready, o_valid, o_last, o_busy, o_done and o_err are 0; o_re/o_im are 0.
- i_start is sampled on the rising edge. COLLECT (o_ready=1) is entered on the next cycle.
- o_valid rises on the cycle after the final input beat, so latency is 1 cycle.
- Output stability: while o_valid && !i_ready, o_re, o_im and o_last hold stable.
- o_done is asserted in the first IDLE cycle after the last transfer, for exactly 1 cycle.
- An i_start in that same cycle is accepted, so frames can run back to back.
- Throughput: one frame takes a minimum of 1 + INT_SAMPLES + TOTAL_SAMPLES cycles.
- Reset mid-frame: the partial frame is discarded, with no o_done and no o_err.

## Test plan
- Ramp, phase 0:
  - Stimulus: i_start; re=n, im=-n for n=0..127, continuous; i_ready=1.
  - Response: outputs re=0,8,...,120 and im=0,-8,...,-120; o_last on output 16; o_valid first high the cycle after beat 127; o_done one cycle after the last transfer.
- Phase 5, same ramp: outputs re=5,13,...,125; no o_err.
- Backpressure:
  - Stimulus: random gaps on i_valid; i_ready toggled at random with 50% duty.
  - Response: identical output sequence; o_re/o_im/o_last stable during every stall; exactly 16 transfers.
- Busy start: i_start at input beat 40 → o_err high for 1 cycle; frame output still equals the phase-0 ramp result.
- Reset in DRAIN after 7 transfers:
  - Response: o_valid=0 and o_busy=0 immediately.
  - A new frame with phase 3 then yields re=3,11,...,123 across a full 16 outputs.
- Back-to-back: i_start asserted in the o_done cycle → second frame accepted with no idle gap beyond that cycle, and both frames are correct.
